// File: rtl/jtdd_colmix_gen.sv
// Colour mixer: priority-PROM layer selection, CPU-shared palette, 4-stage pixel pipeline.
// Optional brightness fade when JTDD_COLMIX_FADE_EN is defined.
module jtdd_colmix_gen #(
   parameter int unsigned LAYERS   = 3,
   parameter int unsigned PXLW     = 7,
   parameter int unsigned CW       = 4,
   parameter int unsigned PALAW    = 9,
   parameter string       SIM_PRIO = ""
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pxl_cen,
   input  logic                     VBL,
   input  logic                     HBL,
   input  logic [LAYERS*PXLW-1:0]   lyr_pxl,
   input  logic                     pal_cs,
   input  logic                     cpu_rnw,
   input  logic [PALAW:0]           cpu_addr,
   input  logic [7:0]               cpu_dout,
   output logic [7:0]               pal_dout,
   output logic                     cpu_ok,
   input  logic [7:0]               prog_addr,
   input  logic [1:0]               prog_din,
   input  logic                     prom_prio_we,
   input  logic                     fade_start,
   input  logic                     fade_dir,
   output logic                     fade_busy,
   output logic [CW-1:0]            red,
   output logic [CW-1:0]            green,
   output logic [CW-1:0]            blue,
   output logic                     LHBL_dly,
   output logic                     LVBL_dly
);

   localparam int unsigned HIW = 8 - LAYERS;
   localparam int unsigned PSH = (PXLW > HIW) ? PXLW - HIW : 0;
   localparam bit unused_sim_prio = (SIM_PRIO != "");

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} cpu_st_e;

   cpu_st_e st_q, st_d;

   logic [1:0]             prio_mem [256];
   logic [7:0]             pal_lo   [2**PALAW];
   logic [7:0]             pal_hi   [2**PALAW];

   logic [LAYERS-1:0]      opaque;
   logic [PXLW-1:0]        lyr1;
   logic [7:0]             prom_addr;
   logic [1:0]             prio_q;
   logic [LAYERS*PXLW-1:0] lyr_q;
   logic [2:0]             hbl_q, vbl_q;
   logic [1:0]             win;
   logic [PXLW-1:0]        sel_pxl;
   logic [PALAW-1:0]       addr_q, port_addr;
   logic [15:0]            pal_q;
   logic [7:0]             lo_rd, hi_rd;
   logic                   cpu_acc;
   logic [4:0]             bright;
   logic [CW+4:0]          prod_r, prod_g, prod_b;

   always_comb begin
      opaque = '0;
      for (int k = 0; k < LAYERS; k++) opaque[k] = |lyr_pxl[k*PXLW +: 4];
   end

   assign lyr1      = lyr_pxl[PXLW +: PXLW];
   assign prom_addr = {HIW'(lyr1 >> PSH), opaque};

   // PROM codes that name a missing layer fall back to layer 0
   assign win       = (32'(prio_q) >= LAYERS) ? 2'd0 : prio_q;
   assign sel_pxl   = lyr_q[32'(win)*PXLW +: PXLW];

   assign cpu_acc   = (st_q == StAccess);
   assign port_addr = cpu_acc ? cpu_addr[PALAW-1:0] : addr_q;
   assign lo_rd     = pal_lo[port_addr];
   assign hi_rd     = pal_hi[port_addr];
   assign cpu_ok    = (st_q == StDone);

   always_ff @(posedge clk) begin
      if (prom_prio_we) prio_mem[prog_addr] <= prog_din;
   end

   // Writes are dropped when reset hits during the access cycle
   always_ff @(posedge clk) begin
      if (cpu_acc && !cpu_rnw && !rst) begin
         if (cpu_addr[PALAW]) pal_hi[port_addr] <= cpu_dout;
         else                 pal_lo[port_addr] <= cpu_dout;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle:   if (pal_cs) st_d = StWait;
         StWait:   if (!pxl_cen) st_d = StAccess;
         StAccess: st_d = StDone;
         StDone:   if (!pal_cs) st_d = StIdle;
         default:  st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= StIdle;
         pal_dout <= 8'd0;
      end else begin
         st_q <= st_d;
         if (cpu_acc && cpu_rnw) pal_dout <= cpu_addr[PALAW] ? hi_rd : lo_rd;
      end
   end

   always_comb begin
      prod_r = (CW+5)'(pal_q[CW-1:0])      * (CW+5)'(bright);
      prod_g = (CW+5)'(pal_q[2*CW-1:CW])   * (CW+5)'(bright);
      prod_b = (CW+5)'(pal_q[3*CW-1:2*CW]) * (CW+5)'(bright);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q   <= 2'd0;
         lyr_q    <= '0;
         hbl_q    <= 3'd0;
         vbl_q    <= 3'd0;
         addr_q   <= '0;
         pal_q    <= 16'd0;
         red      <= '0;
         green    <= '0;
         blue     <= '0;
         LHBL_dly <= 1'b0;
         LVBL_dly <= 1'b0;
      end else if (pxl_cen) begin
         prio_q <= prio_mem[prom_addr];
         lyr_q  <= lyr_pxl;
         hbl_q  <= {hbl_q[1:0], HBL};
         vbl_q  <= {vbl_q[1:0], VBL};
         addr_q <= PALAW'({win, sel_pxl});
         // A CPU access owns the palette port this cycle: keep the last colour
         if (!cpu_acc) pal_q <= {hi_rd, lo_rd};
         if (hbl_q[2] || vbl_q[2]) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end else begin
            red   <= prod_r[CW+3:4];
            green <= prod_g[CW+3:4];
            blue  <= prod_b[CW+3:4];
         end
         LHBL_dly <= ~hbl_q[2];
         LVBL_dly <= ~vbl_q[2];
      end
   end

`ifdef JTDD_COLMIX_FADE_EN
   logic [4:0] bright_q;
   logic       busy_q, dir_q, vbl_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bright_q   <= 5'd16;
         busy_q     <= 1'b0;
         dir_q      <= 1'b0;
         vbl_prev_q <= 1'b0;
      end else begin
         vbl_prev_q <= VBL;
         if (fade_start) begin
            bright_q <= fade_dir ? 5'd0 : 5'd16;
            busy_q   <= 1'b1;
            dir_q    <= fade_dir;
         end else if (busy_q && VBL && !vbl_prev_q) begin
            if (dir_q) begin
               bright_q <= bright_q + 5'd1;
               if (bright_q == 5'd15) busy_q <= 1'b0;
            end else begin
               bright_q <= bright_q - 5'd1;
               if (bright_q == 5'd1) busy_q <= 1'b0;
            end
         end
      end
   end

   assign bright    = bright_q;
   assign fade_busy = busy_q;
`else
   logic unused_fade;
   assign unused_fade = fade_start ^ fade_dir;
   assign bright      = 5'd16;
   assign fade_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_jtdd_colmix_gen.sv
// Directed bench for jtdd_colmix_gen: reset, priority/palette path, blanking alignment,
// CPU palette access handshake, reset during access and the fade control.
module tb_jtdd_colmix_gen;

   logic        clk = 1'b0;
   logic        rst, pxl_cen, VBL, HBL;
   logic [20:0] lyr_pxl;
   logic        pal_cs, cpu_rnw;
   logic [9:0]  cpu_addr;
   logic [7:0]  cpu_dout, pal_dout;
   logic        cpu_ok;
   logic [7:0]  prog_addr;
   logic [1:0]  prog_din;
   logic        prom_prio_we, fade_start, fade_dir, fade_busy;
   logic [3:0]  red, green, blue;
   logic        LHBL_dly, LVBL_dly;

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   jtdd_colmix_gen dut (
      .clk          (clk),
      .rst          (rst),
      .pxl_cen      (pxl_cen),
      .VBL          (VBL),
      .HBL          (HBL),
      .lyr_pxl      (lyr_pxl),
      .pal_cs       (pal_cs),
      .cpu_rnw      (cpu_rnw),
      .cpu_addr     (cpu_addr),
      .cpu_dout     (cpu_dout),
      .pal_dout     (pal_dout),
      .cpu_ok       (cpu_ok),
      .prog_addr    (prog_addr),
      .prog_din     (prog_din),
      .prom_prio_we (prom_prio_we),
      .fade_start   (fade_start),
      .fade_dir     (fade_dir),
      .fade_busy    (fade_busy),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .LHBL_dly     (LHBL_dly),
      .LVBL_dly     (LVBL_dly)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         pxl_cen = 1'b1;
         step();
         pxl_cen = 1'b0;
         step();
      end
   endtask

   task automatic prom_wr(input logic [7:0] a, input logic [1:0] d);
      prog_addr    = a;
      prog_din     = d;
      prom_prio_we = 1'b1;
      step();
      prom_prio_we = 1'b0;
   endtask

   // Raise a request and toggle pxl_cen every clk until cpu_ok; lat counts clk edges
   task automatic cpu_req(input logic rnw, input logic [9:0] a, input logic [7:0] d,
                          output int n);
      pal_cs   = 1'b1;
      cpu_rnw  = rnw;
      cpu_addr = a;
      cpu_dout = d;
      n        = 0;
      while (!cpu_ok && n < 12) begin
         pxl_cen = ~pxl_cen;
         step();
         n++;
      end
      pxl_cen = 1'b0;
      if (!cpu_ok) check("cpu_ok_timeout", {31'd0, cpu_ok}, 32'd1);
   endtask

   task automatic cpu_rel();
      pal_cs = 1'b0;
      step();
   endtask

   task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
      cpu_req(1'b0, a, d, lat);
      cpu_rel();
   endtask

   initial begin
      rst = 1'b1; pxl_cen = 1'b0; VBL = 1'b0; HBL = 1'b0; lyr_pxl = '0;
      pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
      prog_addr = '0; prog_din = '0; prom_prio_we = 1'b0;
      fade_start = 1'b0; fade_dir = 1'b0;
      step(); pxl_cen = 1'b1; step(); pxl_cen = 1'b0; step();

      check("rst_rgb",       {red, green, blue}, 12'h000);
      check("rst_lhbl",      LHBL_dly, 1'b0);
      check("rst_lvbl",      LVBL_dly, 1'b0);
      check("rst_cpu_ok",    cpu_ok, 1'b0);
      check("rst_pal_dout",  pal_dout, 8'h00);
      check("rst_fade_busy", fade_busy, 1'b0);
      rst = 1'b0;
      step();

      prom_wr(8'h00, 2'd0);
      prom_wr(8'h07, 2'd2);
      cpu_wr(10'h000, 8'h21); cpu_wr(10'h200, 8'h04);   // entry 0x000: R1 G2 B4
      cpu_wr(10'h115, 8'hA5); cpu_wr(10'h315, 8'h03);   // entry 0x115: R5 GA B3
      cpu_wr(10'h001, 8'h76); cpu_wr(10'h201, 8'h08);   // entry 0x001: R6 G7 B8

      // Write handshake with pxl_cen toggling, then read back while holding pal_cs
      cpu_req(1'b0, 10'h012, 8'h5A, lat);
      check("wr_cpu_ok_latency", lat <= 4, 1'b1);
      cpu_rel();
      cpu_req(1'b1, 10'h012, 8'h00, lat);
      check("rd_back_5a", pal_dout, 8'h5A);
      step(); step(); step();
      check("cpu_ok_held", cpu_ok, 1'b1);
      check("rd_data_held", pal_dout, 8'h5A);
      cpu_rel();
      check("cpu_ok_drop", cpu_ok, 1'b0);

      // All layers transparent -> PROM 0 -> entry 0x000
      pulses(4);
      check("transp_rgb", {red, green, blue}, 12'h124);
      check("transp_lhbl", LHBL_dly, 1'b1);
      check("transp_lvbl", LVBL_dly, 1'b1);

      // All opaque, layer 1 top bits 0 -> PROM[0x07] = 2 -> layer 2 = 0x15 -> entry 0x115
      lyr_pxl = {7'h15, 7'h01, 7'h01};
      pulses(3);
      check("prio_not_yet", {red, green, blue}, 12'h124);
      pulses(1);
      check("prio_layer2", {red, green, blue}, 12'h5A3);

      // CPU read during streaming: pixel output continues uninterrupted
      cpu_req(1'b1, 10'h115, 8'h00, lat);
      check("rd_115", pal_dout, 8'hA5);
      cpu_rel();
      pulses(4);
      check("stream_after_cpu", {red, green, blue}, 12'h5A3);

      // PROM value 3 is out of range for 3 layers -> layer 0 (0x01) -> entry 0x001
      prom_wr(8'h07, 2'd3);
      pulses(4);
      check("prio_oob_layer0", {red, green, blue}, 12'h678);

      // HBL alignment with transparent layers
      lyr_pxl = '0;
      HBL = 1'b1;
      pulses(3);
      check("hbl_not_yet_rgb", {red, green, blue}, 12'h678);
      check("hbl_not_yet", LHBL_dly, 1'b1);
      pulses(1);
      check("hbl_rgb_zero", {red, green, blue}, 12'h000);
      check("hbl_dly", LHBL_dly, 1'b0);
      HBL = 1'b0; VBL = 1'b1;
      pulses(4);
      check("vbl_rgb_zero", {red, green, blue}, 12'h000);
      check("vbl_dly", {LHBL_dly, LVBL_dly}, 2'b10);
      VBL = 1'b0;
      pulses(4);
      check("unblank_rgb", {red, green, blue}, 12'h124);

      // Reset while the FSM sits in ACCESS (pxl_cen kept low: IDLE->WAIT->ACCESS)
      prom_wr(8'h07, 2'd2);
      lyr_pxl = {7'h15, 7'h01, 7'h01};
      pulses(4);
      check("pre_rst_rgb", {red, green, blue}, 12'h5A3);
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 10'h012; cpu_dout = 8'h99;
      step(); step();
      rst = 1'b1;
      step();
      check("rst_acc_cpu_ok", cpu_ok, 1'b0);
      check("rst_acc_rgb", {red, green, blue}, 12'h000);
      rst = 1'b0; pal_cs = 1'b0;
      step();
      cpu_req(1'b1, 10'h115, 8'h00, lat);
      check("retained_115", pal_dout, 8'hA5);
      cpu_rel();
      pulses(4);
      check("retained_prom_rgb", {red, green, blue}, 12'h5A3);

`ifdef JTDD_COLMIX_FADE_EN
      cpu_wr(10'h115, 8'hAF);                           // red = F
      fade_start = 1'b1; fade_dir = 1'b1;
      step();
      fade_start = 1'b0;
      check("fade_busy_set", fade_busy, 1'b1);
      pulses(4);
      check("fade_start_red", red, 4'h0);
      for (int i = 0; i < 8; i++) begin
         VBL = 1'b1; step(); VBL = 1'b0; step();
      end
      pulses(4);
      check("fade_8_red", red, 4'h7);
      for (int i = 0; i < 8; i++) begin
         VBL = 1'b1; step(); VBL = 1'b0; step();
      end
      pulses(4);
      check("fade_16_red", red, 4'hF);
      check("fade_busy_clr", fade_busy, 1'b0);
`else
      fade_start = 1'b1; fade_dir = 1'b1;
      step();
      fade_start = 1'b0;
      check("fade_ignored_busy", fade_busy, 1'b0);
      pulses(4);
      check("fade_ignored_rgb", {red, green, blue}, 12'h5A3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
